// File: rtl/multi_debounce.sv
// Multi-channel switch debouncer with press/release edge pulses, a long-press
// hold pulse and an optional auto-repeat pulse train per channel.
// Each channel has its own input polarity, synchroniser, debounce counter,
// press FSM, hold counter and repeat counter. Channels share nothing but the
// clock and reset.

module multi_debounce #(
  parameter int unsigned       NUM_CH          = 4,
  parameter int unsigned       DEBOUNCE_LIMIT  = 20,
  parameter int unsigned       HOLD_LIMIT      = 1000,
  parameter int unsigned       REPEAT_PERIOD   = 250,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK = '0
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_CH-1:0] i_Bouncy,
  input  logic [NUM_CH-1:0] i_Repeat_En,
  output logic [NUM_CH-1:0] o_Debounced,
  output logic [NUM_CH-1:0] o_Press,
  output logic [NUM_CH-1:0] o_Release,
  output logic [NUM_CH-1:0] o_Hold,
  output logic [NUM_CH-1:0] o_Repeat
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_LIMIT + 1);
  localparam int unsigned HD_W = $clog2(HOLD_LIMIT + 1);
  localparam int unsigned RP_W = $clog2(REPEAT_PERIOD + 1);

  // Terminal values: the event fires on the edge where the count would
  // reach its limit, so the stored count never exceeds limit-1.
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [HD_W-1:0] HD_MAX = HD_W'(HOLD_LIMIT - 1);
  localparam logic [RP_W-1:0] RP_MAX = RP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StHeld
  } state_e;

  logic [NUM_CH-1:0] w_polarised;
  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;

  // Bring every channel to active-high before it crosses the clock domain.
  assign w_polarised = i_Bouncy ^ ACTIVE_LOW_MASK;

  // Two-flop synchroniser for all raw inputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_polarised;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DB_W-1:0] r_db_cnt;
    logic [DB_W-1:0] w_db_cnt_d;
    logic            r_deb;
    logic            w_deb_d;
    logic            w_toggle;

    state_e          r_state;
    state_e          w_state_d;
    logic [HD_W-1:0] r_hold_cnt;
    logic [HD_W-1:0] w_hold_cnt_d;
    logic [RP_W-1:0] r_rep_cnt;
    logic [RP_W-1:0] w_rep_cnt_d;

    logic            r_press;
    logic            w_press_d;
    logic            r_release;
    logic            w_release_d;
    logic            r_hold;
    logic            w_hold_d;
    logic            r_repeat;
    logic            w_repeat_d;

    // Count consecutive samples that disagree with the debounced level;
    // any agreeing sample restarts the count.
    always_comb begin
      w_db_cnt_d = '0;
      w_deb_d    = r_deb;
      w_toggle   = 1'b0;
      if (r_sync2[g] != r_deb) begin
        if (r_db_cnt == DB_MAX) begin
          w_toggle = 1'b1;
          w_deb_d  = ~r_deb;
        end else begin
          w_db_cnt_d = r_db_cnt + 1'b1;
        end
      end
    end

    // Press FSM with hold and repeat timing; a debounced toggle out of a
    // pressed state is a release and overrides any coinciding threshold.
    always_comb begin
      w_state_d    = r_state;
      w_hold_cnt_d = r_hold_cnt;
      w_rep_cnt_d  = r_rep_cnt;
      w_press_d    = 1'b0;
      w_release_d  = 1'b0;
      w_hold_d     = 1'b0;
      w_repeat_d   = 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_toggle) begin
            w_state_d    = StPressed;
            w_press_d    = 1'b1;
            w_hold_cnt_d = '0;
            w_rep_cnt_d  = '0;
          end
        end
        StPressed: begin
          if (w_toggle) begin
            w_state_d    = StIdle;
            w_release_d  = 1'b1;
            w_hold_cnt_d = '0;
            w_rep_cnt_d  = '0;
          end else if (r_hold_cnt == HD_MAX) begin
            w_state_d    = StHeld;
            w_hold_d     = 1'b1;
            w_hold_cnt_d = '0;
            w_rep_cnt_d  = '0;
          end else begin
            w_hold_cnt_d = r_hold_cnt + 1'b1;
          end
        end
        StHeld: begin
          if (w_toggle) begin
            w_state_d    = StIdle;
            w_release_d  = 1'b1;
            w_hold_cnt_d = '0;
            w_rep_cnt_d  = '0;
          end else if (!i_Repeat_En[g]) begin
            // Disabled repeat parks the count so re-enabling starts afresh.
            w_rep_cnt_d = '0;
          end else if (r_rep_cnt == RP_MAX) begin
            w_repeat_d  = 1'b1;
            w_rep_cnt_d = '0;
          end else begin
            w_rep_cnt_d = r_rep_cnt + 1'b1;
          end
        end
        default: begin
          w_state_d    = StIdle;
          w_hold_cnt_d = '0;
          w_rep_cnt_d  = '0;
        end
      endcase
    end

    // Per-channel state and registered pulse outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        r_db_cnt   <= '0;
        r_deb      <= 1'b0;
        r_state    <= StIdle;
        r_hold_cnt <= '0;
        r_rep_cnt  <= '0;
        r_press    <= 1'b0;
        r_release  <= 1'b0;
        r_hold     <= 1'b0;
        r_repeat   <= 1'b0;
      end else begin
        r_db_cnt   <= w_db_cnt_d;
        r_deb      <= w_deb_d;
        r_state    <= w_state_d;
        r_hold_cnt <= w_hold_cnt_d;
        r_rep_cnt  <= w_rep_cnt_d;
        r_press    <= w_press_d;
        r_release  <= w_release_d;
        r_hold     <= w_hold_d;
        r_repeat   <= w_repeat_d;
      end
    end

    assign o_Debounced[g] = r_deb;
    assign o_Press[g]     = r_press;
    assign o_Release[g]   = r_release;
    assign o_Hold[g]      = r_hold;
    assign o_Repeat[g]    = r_repeat;
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Bench for multi_debounce: directed scenarios plus randomized stimulus,
// every cycle compared against an event-level reference model.

module tb_multi_debounce;

  localparam int NUM_CH = 4;
  localparam int DL     = 8;
  localparam int HL     = 32;
  localparam int RP     = 16;
  localparam logic [NUM_CH-1:0] MASK = 4'b1000;
  // Raw input pattern with every channel at its inactive level.
  localparam logic [NUM_CH-1:0] IDLE_IN = MASK;

  logic              i_Clk = 1'b0;
  logic              i_Rst_L = 1'b1;
  logic [NUM_CH-1:0] i_Bouncy;
  logic [NUM_CH-1:0] i_Repeat_En;
  logic [NUM_CH-1:0] o_Debounced;
  logic [NUM_CH-1:0] o_Press;
  logic [NUM_CH-1:0] o_Release;
  logic [NUM_CH-1:0] o_Hold;
  logic [NUM_CH-1:0] o_Repeat;

  multi_debounce #(
    .NUM_CH         (NUM_CH),
    .DEBOUNCE_LIMIT (DL),
    .HOLD_LIMIT     (HL),
    .REPEAT_PERIOD  (RP),
    .ACTIVE_LOW_MASK(MASK)
  ) u_dut (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Bouncy   (i_Bouncy),
    .i_Repeat_En(i_Repeat_En),
    .o_Debounced(o_Debounced),
    .o_Press    (o_Press),
    .o_Release  (o_Release),
    .o_Hold     (o_Hold),
    .o_Repeat   (o_Repeat)
  );

  always #5 i_Clk = ~i_Clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  tag, obs, obs, exp, exp, cyc);
  endtask

  // Reference model: a level changes once the last DL synchronised samples
  // all disagree with it; hold/repeat are timed from press and enable edges.
  logic [NUM_CH-1:0] raw_log[$];
  logic [NUM_CH-1:0] m_deb, m_held;
  logic [NUM_CH-1:0] e_press, e_release, e_hold, e_repeat;
  int                m_press_t[NUM_CH];
  int                m_base[NUM_CH];

  task automatic model_reset();
    raw_log.delete();
    m_deb = '0; m_held = '0;
    e_press = '0; e_release = '0; e_hold = '0; e_repeat = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_press_t[ch] = 0;
      m_base[ch]    = 0;
    end
  endtask

  task automatic model_edge();
    int   t;
    logic s;
    logic stable;
    raw_log.push_back(i_Bouncy ^ MASK);
    t = raw_log.size() - 1;
    e_press = '0; e_release = '0; e_hold = '0; e_repeat = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      stable = (t >= DL - 1);
      for (int k = 0; k < DL; k++) begin
        int e;
        e = t - k;
        // Synchronised sample seen at edge e is the raw value of edge e-2.
        s = (e >= 2) ? raw_log[e-2][ch] : 1'b0;
        if (s == m_deb[ch]) stable = 1'b0;
      end
      if (stable) begin
        m_deb[ch] = ~m_deb[ch];
        if (m_deb[ch]) begin
          e_press[ch]   = 1'b1;
          m_press_t[ch] = t;
        end else begin
          e_release[ch] = 1'b1;
          m_held[ch]    = 1'b0;
        end
      end else if (m_deb[ch] && !m_held[ch]) begin
        if (t - m_press_t[ch] == HL) begin
          e_hold[ch] = 1'b1;
          m_held[ch] = 1'b1;
          m_base[ch] = t;
        end
      end else if (m_held[ch]) begin
        if (!i_Repeat_En[ch]) m_base[ch] = t;
        else if ((t - m_base[ch]) % RP == 0) e_repeat[ch] = 1'b1;
      end
    end
  endtask

  // Observed pulse tallies and timestamps for the directed scenarios.
  int n_press[NUM_CH], n_release[NUM_CH], n_hold[NUM_CH], n_repeat[NUM_CH];
  int t_press[NUM_CH], t_release[NUM_CH], t_hold[NUM_CH];
  int rep_q[$];

  task automatic clear_tally();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      n_press[ch] = 0; n_release[ch] = 0; n_hold[ch] = 0; n_repeat[ch] = 0;
      t_press[ch] = -1000; t_release[ch] = -1000; t_hold[ch] = -1000;
    end
    rep_q.delete();
  endtask

  task automatic do_cycle();
    @(posedge i_Clk);
    if (i_Rst_L) model_edge();
    @(negedge i_Clk);
    cyc++;
    check("debounced", 32'(o_Debounced), 32'(m_deb));
    check("press",     32'(o_Press),     32'(e_press));
    check("release",   32'(o_Release),   32'(e_release));
    check("hold",      32'(o_Hold),      32'(e_hold));
    check("repeat",    32'(o_Repeat),    32'(e_repeat));
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (o_Press[ch])   begin n_press[ch]++;   t_press[ch]   = cyc; end
      if (o_Release[ch]) begin n_release[ch]++; t_release[ch] = cyc; end
      if (o_Hold[ch])    begin n_hold[ch]++;    t_hold[ch]    = cyc; end
      if (o_Repeat[ch]) begin
        n_repeat[ch]++;
        if (ch == 2) rep_q.push_back(cyc - t_press[2]);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  // Asserts reset between clock edges and checks outputs clear immediately.
  task automatic apply_reset(input int n);
    i_Rst_L = 1'b0;
    #1;
    check("rst_debounced", 32'(o_Debounced), 32'd0);
    check("rst_press",     32'(o_Press),     32'd0);
    check("rst_release",   32'(o_Release),   32'd0);
    check("rst_hold",      32'(o_Hold),      32'd0);
    check("rst_repeat",    32'(o_Repeat),    32'd0);
    model_reset();
    run(n);
    i_Rst_L = 1'b1;
  endtask

  int rem[NUM_CH];

  initial begin
    int c0;
    int c_drop;
    int r0, r1;
    int idx;
    i_Bouncy    = IDLE_IN;
    i_Repeat_En = '0;
    model_reset();
    clear_tally();
    #2;
    apply_reset(3);

    // Single step on ch0: press exactly DL+2 cycles after the first sample.
    clear_tally();
    c0 = cyc;
    i_Bouncy[0] = 1'b1;
    run(20);
    check("ch0_press_latency", 32'(t_press[0] - c0), 32'd10);
    check("ch0_press_count",   32'(n_press[0]), 32'd1);
    check("other_press_count", 32'(n_press[1] + n_press[2] + n_press[3]), 32'd0);
    i_Bouncy[0] = 1'b0;
    run(20);
    check("ch0_release_count", 32'(n_release[0]), 32'd1);

    // 5-cycle pulses on ch1 never survive the debounce window.
    clear_tally();
    for (int i = 0; i < 20; i++) begin
      i_Bouncy[1] = ~i_Bouncy[1];
      run(5);
    end
    i_Bouncy[1] = 1'b0;
    run(5);
    check("ch1_glitch_press",   32'(n_press[1]), 32'd0);
    check("ch1_glitch_release", 32'(n_release[1]), 32'd0);

    // Long press on ch2 with auto-repeat enabled.
    clear_tally();
    i_Repeat_En = 4'b0100;
    c0 = cyc;
    i_Bouncy[2] = 1'b1;
    run(90);
    c_drop = cyc;
    i_Bouncy[2] = 1'b0;
    run(20);
    r0 = (rep_q.size() > 0) ? rep_q[0] : -1;
    r1 = (rep_q.size() > 1) ? rep_q[1] : -1;
    check("ch2_press_latency",   32'(t_press[2] - c0), 32'd10);
    check("ch2_hold_offset",     32'(t_hold[2] - t_press[2]), 32'd32);
    check("ch2_hold_count",      32'(n_hold[2]), 32'd1);
    check("ch2_repeat0_offset",  32'(r0), 32'd48);
    check("ch2_repeat1_offset",  32'(r1), 32'd64);
    check("ch2_release_latency", 32'(t_release[2] - c_drop), 32'd10);
    i_Repeat_En = '0;

    // Active-low ch3: driving the pin low is a press.
    clear_tally();
    i_Bouncy[3] = 1'b0;
    run(20);
    check("ch3_press_count", 32'(n_press[3]), 32'd1);
    i_Bouncy[3] = 1'b1;
    run(20);
    check("ch3_release_count", 32'(n_release[3]), 32'd1);

    // Reset during a ch0 debounce discards progress; a fresh one completes.
    clear_tally();
    i_Bouncy[0] = 1'b1;
    run(5);
    apply_reset(3);
    c0 = cyc;
    run(20);
    check("rst_mid_press_latency", 32'(t_press[0] - c0), 32'd10);
    check("rst_mid_press_count",   32'(n_press[0]), 32'd1);
    i_Bouncy[0] = 1'b0;
    run(20);

    // Release lands on the same edge the hold count would expire.
    clear_tally();
    i_Bouncy[0] = 1'b1;
    run(10);
    check("coinc_press_count", 32'(n_press[0]), 32'd1);
    run(22);
    i_Bouncy[0] = 1'b0;
    run(30);
    check("coinc_hold_count",     32'(n_hold[0]), 32'd0);
    check("coinc_release_count",  32'(n_release[0]), 32'd1);
    check("coinc_release_offset", 32'(t_release[0] - t_press[0]), 32'd32);

    // Randomized mix of bounces, long presses and repeat-enable changes.
    for (int ch = 0; ch < NUM_CH; ch++) rem[ch] = $urandom_range(1, 50);
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (rem[ch] == 0) begin
          i_Bouncy[ch] = ~i_Bouncy[ch];
          rem[ch] = ($urandom_range(0, 2) == 0) ? $urandom_range(40, 200)
                                                : $urandom_range(1, 12);
        end else begin
          rem[ch]--;
        end
      end
      if ($urandom_range(0, 39) == 0) begin
        idx = $urandom_range(0, NUM_CH - 1);
        i_Repeat_En[idx] = ~i_Repeat_En[idx];
      end
      if (c == 1500) apply_reset($urandom_range(1, 4));
      else do_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/multi_debounce.md
MULTI_DEBOUNCE -- requirements
Module: Multi_Debounce

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent input channels; legal range 1..32.
REQ-002 Parameter DEBOUNCE_LIMIT, default 20: consecutive stable cycles required before a debounced output changes; minimum 2.
REQ-003 Parameter HOLD_LIMIT, default 1000: cycles a channel stays debounced-high before the long-press pulse fires; must be greater than DEBOUNCE_LIMIT.
REQ-004 Parameter REPEAT_PERIOD, default 250: cycles between auto-repeat pulses after a long press; minimum 1.
REQ-005 Parameter ACTIVE_LOW_MASK [NUM_CH-1:0], default 0: a set bit inverts that channel's raw input before synchronisation.
REQ-006 i_Clk  input  1  single system clock; all state updates on the rising edge.
REQ-007 i_Rst_L  input  1  asynchronous active-low reset.
REQ-008 i_Bouncy  input  NUM_CH  raw asynchronous switch/button inputs.
REQ-009 i_Repeat_En  input  NUM_CH  per-channel auto-repeat enable, sampled synchronously.
REQ-010 o_Debounced  output  NUM_CH  debounced level per channel.
REQ-011 o_Press  output  NUM_CH  one-cycle pulse on a debounced 0->1 transition.
REQ-012 o_Release  output  NUM_CH  one-cycle pulse on a debounced 1->0 transition.
REQ-013 o_Hold  output  NUM_CH  one-cycle pulse when the long-press threshold is reached.
REQ-014 o_Repeat  output  NUM_CH  one-cycle auto-repeat pulse train.

Function
REQ-015 Each channel SHALL apply its ACTIVE_LOW_MASK inversion, then pass through a 2-flop synchroniser; channels are fully independent.
REQ-016 Debounce counter SHALL be $clog2(DEBOUNCE_LIMIT+1) bits wide; it increments on each edge where the synchronised input differs from o_Debounced, and clears to 0 on any edge where they match.
REQ-017 On the edge where the counter would reach DEBOUNCE_LIMIT, o_Debounced SHALL toggle and the counter clears; total latency from the first edge sampling a stable new level to the o_Debounced change is DEBOUNCE_LIMIT+2 cycles.
REQ-018 A glitch shorter than DEBOUNCE_LIMIT cycles at the synchroniser output SHALL produce no change on any output.
REQ-019 o_Press/o_Release SHALL assert in the same cycle o_Debounced changes, for exactly one cycle.
REQ-020 Per-channel FSM SHALL have states IDLE (debounced 0), PRESSED, HELD; IDLE->PRESSED on press, PRESSED->HELD on hold-count expiry, any state->IDLE on release.
REQ-021 Hold counter ($clog2(HOLD_LIMIT+1) bits) SHALL clear on press and increment each cycle in PRESSED; o_Hold pulses on the cycle the FSM enters HELD, HOLD_LIMIT cycles after o_Press.
REQ-022 In HELD with i_Repeat_En set, a repeat counter SHALL emit o_Repeat every REPEAT_PERIOD cycles, the first pulse REPEAT_PERIOD cycles after o_Hold; with i_Repeat_En clear the counter holds at 0 and no pulses are emitted.
REQ-023 Deasserting i_Repeat_En mid-train SHALL stop pulses the next cycle; reasserting restarts the count from 0.
REQ-024 Release SHALL take priority: on the o_Release cycle, o_Hold and o_Repeat are 0 and all counters clear, even if a threshold coincides.
REQ-025 Counters SHALL never wrap; each saturates or clears at its limit.

Reset
REQ-026 While i_Rst_L=0, all synchroniser flops, counters and o_Debounced SHALL be 0, the FSM SHALL be IDLE, and all pulse outputs SHALL be 0, asynchronously.
REQ-027 After reset release, an input already at active level SHALL yield o_Press after DEBOUNCE_LIMIT+2 cycles; no pulse is generated by reset itself.
REQ-028 Reset asserted mid-debounce or mid-hold SHALL discard all progress with no spurious pulses on release.

Verification (NUM_CH=4, DEBOUNCE_LIMIT=8, HOLD_LIMIT=32, REPEAT_PERIOD=16)
REQ-029 Ch0 steps 0->1 and holds -> o_Debounced[0]=1 and a single o_Press[0] pulse exactly 10 cycles later; other channels remain 0.
REQ-030 Ch1 toggles with 5-cycle pulses for 100 cycles -> no output activity on ch1.
REQ-031 Ch2 held 80 cycles after press with i_Repeat_En[2]=1 -> o_Hold[2] at press+32, o_Repeat[2] at +48 and +64, then o_Release[2] 10 cycles after the input drops.
REQ-032 ACTIVE_LOW_MASK=4'b1000, ch3 input driven to 0 -> o_Press[3]; input returned to 1 -> o_Release[3].
REQ-033 Reset pulsed at cycle 5 of a ch0 debounce -> all outputs stay 0; a fresh debounce completes 10 cycles after reset release.
REQ-034 Release crosses the threshold on the same cycle as hold-count expiry -> o_Release only; o_Hold stays 0.
